// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: time-multiplexed seven-segment driver with tear-free shadow value and PWM dimming.
// Optional feature: define SSD_LZB_EN to blank leading zero digits.
module ssd_scan_controller #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned DIV_W    = 17,
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [4*N_DIGITS-1:0] Value,
  input  logic                  Load,
  input  logic [N_DIGITS-1:0]   Dp_in,
  input  logic [N_DIGITS-1:0]   Digit_en,
  input  logic [BRIGHT_W-1:0]   Bright,
  output logic [N_DIGITS-1:0]   An,
  output logic [6:0]            Cath,
  output logic                  Dp,
  output logic                  Frame_start
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * N_DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]    dcnt_q, dcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VAL_W-1:0]    shadow_q, shadow_d;
  logic [VAL_W-1:0]    staging_q, staging_d;
  logic                pending_q, pending_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          cath_q, cath_d;
  logic                dp_q, dp_d;
  logic                frame_start_q, frame_start_d;

  logic [N_DIGITS-1:0] blank_mask;
  logic                dcnt_wrap, frame_end;
  logic [3:0]          nib;
  logic                en_sel, dp_sel, blank_sel, lit, active;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h01;
      4'h1: hex_seg = 7'h4F;
      4'h2: hex_seg = 7'h12;
      4'h3: hex_seg = 7'h06;
      4'h4: hex_seg = 7'h4C;
      4'h5: hex_seg = 7'h24;
      4'h6: hex_seg = 7'h20;
      4'h7: hex_seg = 7'h0F;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h04;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h60;
      4'hC: hex_seg = 7'h31;
      4'hD: hex_seg = 7'h42;
      4'hE: hex_seg = 7'h30;
      default: hex_seg = 7'h38;
    endcase
  endfunction

`ifdef SSD_LZB_EN
  // Shadow only changes at frame boundaries, so the mask does too.
  logic seen_nz;
  always_comb begin
    blank_mask = '0;
    seen_nz    = 1'b0;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      if (shadow_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      blank_mask[i] = ~seen_nz;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Scan counters, tear-free value capture and registered pin drive.
  always_comb begin
    dcnt_wrap     = &dcnt_q;
    frame_end     = dcnt_wrap && (idx_q == IDX_LAST);
    dcnt_d        = dcnt_q + DIV_W'(1);
    idx_d         = idx_q;
    staging_d     = staging_q;
    pending_d     = pending_q;
    shadow_d      = shadow_q;
    nib           = 4'h0;
    en_sel        = 1'b0;
    dp_sel        = 1'b0;
    blank_sel     = 1'b0;
    an_d          = '1;

    if (dcnt_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    if (Load) staging_d = Value;
    if (frame_end) begin
      if (Load)           shadow_d = Value;
      else if (pending_q) shadow_d = staging_q;
      pending_d = 1'b0;
    end else if (Load) begin
      pending_d = 1'b1;
    end

    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = shadow_q[4*i +: 4];
        en_sel    = Digit_en[i];
        dp_sel    = Dp_in[i];
        blank_sel = blank_mask[i];
      end
    end

    lit    = (dcnt_q[DIV_W-1 -: BRIGHT_W] <= Bright);
    active = lit && en_sel;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) an_d[i] = ~active;
    end
    cath_d        = (active && !blank_sel) ? hex_seg(nib) : 7'h7F;
    dp_d          = ~(active && dp_sel);
    frame_start_d = (dcnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dcnt_q        <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      staging_q     <= '0;
      pending_q     <= 1'b0;
      an_q          <= '1;
      cath_q        <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      dcnt_q        <= dcnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      staging_q     <= staging_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      cath_q        <= cath_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign An          = an_q;
  assign Cath        = cath_q;
  assign Dp          = dp_q;
  assign Frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with N_DIGITS=4, DIV_W=4, BRIGHT_W=2 (64-cycle frame).
// Builds with or without SSD_LZB_EN; expectations follow the macro.
module tb_ssd_scan_controller;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] Value;
  logic        Load;
  logic [3:0]  Dp_in;
  logic [3:0]  Digit_en;
  logic [1:0]  Bright;
  logic [3:0]  An;
  logic [6:0]  Cath;
  logic        Dp;
  logic        Frame_start;

  int tests = 0;
  int fails = 0;

  ssd_scan_controller #(.N_DIGITS(4), .DIV_W(4), .BRIGHT_W(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Value(Value), .Load(Load), .Dp_in(Dp_in),
    .Digit_en(Digit_en), .Bright(Bright), .An(An), .Cath(Cath), .Dp(Dp),
    .Frame_start(Frame_start)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Advance to the next Frame_start sample, bounded.
  task automatic wait_fs();
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (Frame_start === 1'b1) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wait_fs: no Frame_start within 200 cycles (got 0, need 1)");
    end
  endtask

  task automatic load_value(input logic [15:0] v);
    Value = v;
    Load  = 1'b1;
    step();
    Load  = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Load = 1'b0; Value = 16'h0;
    Dp_in = 4'b0000; Digit_en = 4'b1111; Bright = 2'b11;
    repeat (3) step();
    tests++;
    if (An !== 4'b1111 || Cath !== 7'h7F || Dp !== 1'b1 || Frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: An=%b Cath=%h Dp=%b FS=%b need 1111/7f/1/0", An, Cath, Dp, Frame_start);
    end
    Reset_n = 1'b1;
    step();
    tests++;
    if (An !== 4'b1110 || Frame_start !== 1'b1 || Cath !== 7'h01 || Dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: An=%b FS=%b Cath=%h Dp=%b need 1110/1/01/1", An, Frame_start, Cath, Dp);
    end
    step();
    tests++;
    if (An !== 4'b1110 || Frame_start !== 1'b0) begin
      fails++;
      $display("FAIL fs_pulse: An=%b FS=%b need 1110/0", An, Frame_start);
    end
  endtask

  task automatic test_scan();
    logic [15:0] v;
    logic [3:0]  exp_an;
    logic [6:0]  exp_cath;
    int d;
    v = 16'h1234;
    load_value(v);
    wait_fs();
    for (int k = 0; k < 64; k++) begin
      d        = k / 16;
      exp_an   = ~(4'b0001 << d);
      exp_cath = seg(v[4*d +: 4]);
      tests++;
      if (An !== exp_an || Cath !== exp_cath || Frame_start !== 1'(k == 0)) begin
        fails++;
        $display("FAIL scan k=%0d: An=%b Cath=%b FS=%b need %b/%b/%b", k, An, Cath, Frame_start, exp_an, exp_cath, 1'(k == 0));
      end
      step();
    end
    tests++;
    if (Frame_start !== 1'b1) begin
      fails++;
      $display("FAIL scan_period: FS=%b at cycle 64, need 1", Frame_start);
    end
  endtask

  // Load mid-frame must not disturb the frame being shown.
  task automatic test_anti_tear();
    logic [15:0] v;
    logic [6:0]  exp_cath;
    for (int f = 0; f < 2; f++) begin
      v = (f == 0) ? 16'h1234 : 16'hABCD;
      for (int k = 0; k < 64; k++) begin
        exp_cath = seg(v[4*(k/16) +: 4]);
        tests++;
        if (Cath !== exp_cath || Frame_start !== 1'(k == 0)) begin
          fails++;
          $display("FAIL anti_tear f=%0d k=%0d: Cath=%b FS=%b need %b/%b", f, k, Cath, Frame_start, exp_cath, 1'(k == 0));
        end
        if (f == 0 && k == 20) begin
          Value = 16'hABCD;
          Load  = 1'b1;
        end
        if (f == 0 && k == 21) Load = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_pwm_enable();
    int          low_cnt [4];
    int          thr;
    int          d;
    int          exp_cnt;
    logic        lit;
    logic [3:0]  exp_an;
    logic        exp_dp;
    Digit_en = 4'b1011;
    Dp_in    = 4'b0010;
    for (int b = 1; b >= 0; b--) begin
      Bright = 2'(b);
      thr    = (b + 1) * 4;
      wait_fs();
      for (int i = 0; i < 4; i++) low_cnt[i] = 0;
      for (int k = 0; k < 64; k++) begin
        d      = k / 16;
        lit    = (k % 16) < thr;
        exp_an = (lit && d != 2) ? ~(4'b0001 << d) : 4'b1111;
        exp_dp = !(lit && d == 1);
        tests++;
        if (An !== exp_an || Dp !== exp_dp) begin
          fails++;
          $display("FAIL pwm b=%0d k=%0d: An=%b Dp=%b need %b/%b", b, k, An, Dp, exp_an, exp_dp);
        end
        for (int i = 0; i < 4; i++) if (An[i] === 1'b0) low_cnt[i]++;
        step();
      end
      tests++;
      if (Frame_start !== 1'b1) begin
        fails++;
        $display("FAIL pwm_period b=%0d: FS=%b at cycle 64, need 1", b, Frame_start);
      end
      for (int i = 0; i < 4; i++) begin
        exp_cnt = (i == 2) ? 0 : thr;
        tests++;
        if (low_cnt[i] != exp_cnt) begin
          fails++;
          $display("FAIL pwm_duty b=%0d an%0d: low %0d cycles, need %0d", b, i, low_cnt[i], exp_cnt);
        end
      end
    end
    Bright   = 2'b11;
    Digit_en = 4'b1111;
    Dp_in    = 4'b0000;
  endtask

  task automatic test_lzb();
    logic [15:0] vals [2];
    logic [6:0]  exp  [2][4];
    logic [3:0]  exp_an;
    int d;
    vals = '{16'h0050, 16'h0000};
`ifdef SSD_LZB_EN
    exp = '{'{7'h01, 7'h24, 7'h7F, 7'h7F}, '{7'h01, 7'h7F, 7'h7F, 7'h7F}};
`else
    exp = '{'{7'h01, 7'h24, 7'h01, 7'h01}, '{7'h01, 7'h01, 7'h01, 7'h01}};
`endif
    Dp_in = 4'b1000;
    for (int t = 0; t < 2; t++) begin
      load_value(vals[t]);
      wait_fs();
      for (int k = 0; k < 64; k++) begin
        d      = k / 16;
        exp_an = ~(4'b0001 << d);
        tests++;
        if (An !== exp_an || Cath !== exp[t][d] || Dp !== 1'(d != 3)) begin
          fails++;
          $display("FAIL lzb t=%0d k=%0d: An=%b Cath=%h Dp=%b need %b/%h/%b", t, k, An, Cath, Dp, exp_an, exp[t][d], 1'(d != 3));
        end
        step();
      end
    end
    Dp_in = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_an;
    logic [6:0] exp_cath;
    int d;
    load_value(16'h8888);
    wait_fs();
    repeat (28) step();
    load_value(16'h9999);
    Reset_n = 1'b0;
    step();
    tests++;
    if (An !== 4'b1111 || Cath !== 7'h7F || Dp !== 1'b1 || Frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_off: An=%b Cath=%h Dp=%b FS=%b need 1111/7f/1/0", An, Cath, Dp, Frame_start);
    end
    repeat (2) step();
    Reset_n = 1'b1;
    step();
    for (int k = 0; k < 128; k++) begin
      d      = (k % 64) / 16;
      exp_an = ~(4'b0001 << d);
`ifdef SSD_LZB_EN
      exp_cath = (d == 0) ? 7'h01 : 7'h7F;
`else
      exp_cath = 7'h01;
`endif
      tests++;
      if (An !== exp_an || Cath !== exp_cath || Frame_start !== 1'(k % 64 == 0)) begin
        fails++;
        $display("FAIL reset_mid k=%0d: An=%b Cath=%h FS=%b need %b/%h/%b", k, An, Cath, Frame_start, exp_an, exp_cath, 1'(k % 64 == 0));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_anti_tear();
    test_pwm_enable();
    test_lzb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
